// File: rtl/act_loop_ctrl.sv
// Activation-fetch loop controller: walks act/row/block/frame/patch/layer through a
// req/ack handshake and reports the position of each pending beat to the PE array.
module act_loop_ctrl #(
  parameter int LEN_W = 5,
  parameter int BLK_W = 6,
  parameter int FRM_W = 4,
  parameter int PAT_W = 8,
  parameter int LAY_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] CFG_LenRow,
  input  logic [LEN_W-1:0] CFG_NumRow,
  input  logic [LEN_W-1:0] CFG_DropRow,
  input  logic [BLK_W-1:0] CFG_NumBlk,
  input  logic [FRM_W-1:0] CFG_NumFrm,
  input  logic [PAT_W-1:0] CFG_NumPat,
  input  logic [LAY_W-1:0] CFG_NumLay,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic             frt_row,
  output logic             lst_row,
  output logic             frt_blk,
  output logic             lst_blk,
  output logic             lst_frm,
  output logic             lst_pat,
  output logic             lst_lay,
  output logic             val_psum,
  output logic             fnh_frm,
  output logic             done,
  output logic             busy,
  output logic [BLK_W-1:0] cnt_blk,
  output logic [FRM_W-1:0] cnt_frm,
  output logic [PAT_W-1:0] cnt_pat,
  output logic [LAY_W-1:0] cnt_lay
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_row_q, num_row_q, drop_row_q;
  logic [BLK_W-1:0] num_blk_q;
  logic [FRM_W-1:0] num_frm_q;
  logic [PAT_W-1:0] num_pat_q;
  logic [LAY_W-1:0] num_lay_q;
  logic [LEN_W-1:0] cnt_act_q, cnt_row_q;
  logic [BLK_W-1:0] cnt_blk_q;
  logic [FRM_W-1:0] cnt_frm_q;
  logic [PAT_W-1:0] cnt_pat_q;
  logic [LAY_W-1:0] cnt_lay_q;
  logic             fnh_frm_q, done_q;
  logic             beat, pat_end;

  assign fetch_req = (state_q == RUN) && !abort;
  assign beat      = fetch_req && fetch_ack;
  assign busy      = (state_q != IDLE);
  assign fnh_frm   = fnh_frm_q;
  assign done      = done_q;
  assign cnt_blk   = cnt_blk_q;
  assign cnt_frm   = cnt_frm_q;
  assign cnt_pat   = cnt_pat_q;
  assign cnt_lay   = cnt_lay_q;

  // Flags describe the pending beat, so they depend only on counters and shadow config.
  assign frt_row  = (cnt_act_q == '0);
  assign lst_row  = (cnt_act_q == len_row_q);
  assign frt_blk  = (cnt_blk_q == '0);
  assign lst_blk  = lst_row && (cnt_row_q == num_row_q);
  assign lst_frm  = lst_blk && (cnt_blk_q == num_blk_q);
  assign lst_pat  = lst_frm && (cnt_frm_q == num_frm_q);
  assign pat_end  = lst_pat && (cnt_pat_q == num_pat_q);
  assign lst_lay  = pat_end && (cnt_lay_q == num_lay_q);
  assign val_psum = (cnt_row_q >= drop_row_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_row_q  <= '0;
      num_row_q  <= '0;
      drop_row_q <= '0;
      num_blk_q  <= '0;
      num_frm_q  <= '0;
      num_pat_q  <= '0;
      num_lay_q  <= '0;
      cnt_act_q  <= '0;
      cnt_row_q  <= '0;
      cnt_blk_q  <= '0;
      cnt_frm_q  <= '0;
      cnt_pat_q  <= '0;
      cnt_lay_q  <= '0;
      fnh_frm_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fnh_frm_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        cnt_act_q <= '0;
        cnt_row_q <= '0;
        cnt_blk_q <= '0;
        cnt_frm_q <= '0;
        cnt_pat_q <= '0;
        cnt_lay_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= RUN;
              len_row_q  <= CFG_LenRow;
              num_row_q  <= CFG_NumRow;
              drop_row_q <= CFG_DropRow;
              num_blk_q  <= CFG_NumBlk;
              num_frm_q  <= CFG_NumFrm;
              num_pat_q  <= CFG_NumPat;
              num_lay_q  <= CFG_NumLay;
            end
          end
          RUN: begin
            if (beat) begin
              fnh_frm_q <= lst_frm;
              if (lst_lay) begin
                state_q   <= FIN;
                done_q    <= 1'b1;
                cnt_act_q <= '0;
                cnt_row_q <= '0;
                cnt_blk_q <= '0;
                cnt_frm_q <= '0;
                cnt_pat_q <= '0;
                cnt_lay_q <= '0;
              end else begin
                // Each level steps only when everything inside it is at its last value.
                cnt_act_q <= lst_row ? '0 : cnt_act_q + LEN_W'(1);
                if (lst_row) cnt_row_q <= lst_blk ? '0 : cnt_row_q + LEN_W'(1);
                if (lst_blk) cnt_blk_q <= lst_frm ? '0 : cnt_blk_q + BLK_W'(1);
                if (lst_frm) cnt_frm_q <= lst_pat ? '0 : cnt_frm_q + FRM_W'(1);
                if (lst_pat) cnt_pat_q <= pat_end ? '0 : cnt_pat_q + PAT_W'(1);
                if (pat_end) cnt_lay_q <= cnt_lay_q + LAY_W'(1);
              end
            end
          end
          FIN:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_act_loop_ctrl.sv
// Directed bench for act_loop_ctrl: per-cycle flag/counter checks against beat-index arithmetic.
module tb_act_loop_ctrl;
  localparam int LEN_W = 5;
  localparam int BLK_W = 6;
  localparam int FRM_W = 4;
  localparam int PAT_W = 8;
  localparam int LAY_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             fetch_ack = 1'b0;
  logic [LEN_W-1:0] CFG_LenRow = '0, CFG_NumRow = '0, CFG_DropRow = '0;
  logic [BLK_W-1:0] CFG_NumBlk = '0;
  logic [FRM_W-1:0] CFG_NumFrm = '0;
  logic [PAT_W-1:0] CFG_NumPat = '0;
  logic [LAY_W-1:0] CFG_NumLay = '0;
  logic             fetch_req;
  logic             frt_row, lst_row, frt_blk, lst_blk, lst_frm, lst_pat, lst_lay;
  logic             val_psum, fnh_frm, done, busy;
  logic [BLK_W-1:0] cnt_blk;
  logic [FRM_W-1:0] cnt_frm;
  logic [PAT_W-1:0] cnt_pat;
  logic [LAY_W-1:0] cnt_lay;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  act_loop_ctrl #(
    .LEN_W(LEN_W), .BLK_W(BLK_W), .FRM_W(FRM_W), .PAT_W(PAT_W), .LAY_W(LAY_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .CFG_LenRow(CFG_LenRow), .CFG_NumRow(CFG_NumRow), .CFG_DropRow(CFG_DropRow),
    .CFG_NumBlk(CFG_NumBlk), .CFG_NumFrm(CFG_NumFrm), .CFG_NumPat(CFG_NumPat),
    .CFG_NumLay(CFG_NumLay),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .frt_row(frt_row), .lst_row(lst_row), .frt_blk(frt_blk), .lst_blk(lst_blk),
    .lst_frm(lst_frm), .lst_pat(lst_pat), .lst_lay(lst_lay),
    .val_psum(val_psum), .fnh_frm(fnh_frm), .done(done), .busy(busy),
    .cnt_blk(cnt_blk), .cnt_frm(cnt_frm), .cnt_pat(cnt_pat), .cnt_lay(cnt_lay)
  );

  // Starts a traversal and checks every cycle against the expected position of beat k.
  task automatic run_and_check(input string tag, input int lr, input int nr, input int dr,
                               input int nb, input int nf, input int np, input int nl,
                               input int ack_pct, input int abort_at, input bit poke,
                               output int beats);
    int total, k, cyc, a, r, b, f, p, l, q;
    logic [7:0] got_f, exp_f;
    logic [BLK_W+FRM_W+PAT_W+LAY_W-1:0] got_c, exp_c;
    logic exp_fnh, fnh_next;
    total = (lr + 1) * (nr + 1) * (nb + 1) * (nf + 1) * (np + 1) * (nl + 1);
    @(negedge clk);
    CFG_LenRow = LEN_W'(lr); CFG_NumRow = LEN_W'(nr); CFG_DropRow = LEN_W'(dr);
    CFG_NumBlk = BLK_W'(nb); CFG_NumFrm = FRM_W'(nf); CFG_NumPat = PAT_W'(np);
    CFG_NumLay = LAY_W'(nl);
    start = 1'b1; fetch_ack = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s busy_before_start: got %b want 0", tag, busy);
    end
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0; exp_fnh = 1'b0; beats = 0;
    while (k < total && cyc < 5000) begin
      fetch_ack = ($urandom_range(99) < ack_pct);
      if (poke && cyc == 10) begin
        start = 1'b1;
        CFG_LenRow = 5'd1; CFG_NumRow = 5'd0; CFG_NumBlk = 6'd3;
        CFG_NumFrm = 4'd0; CFG_NumLay = 5'd4;
      end else begin
        start = 1'b0;
      end
      if (abort_at >= 0 && k == abort_at) begin
        abort = 1'b1; fetch_ack = 1'b1;
      end
      #1;
      if (abort) begin
        n_cmp++;
        if (fetch_req !== 1'b0) begin
          n_err++; $display("FAIL %s abort_req: got %b want 0", tag, fetch_req);
        end
        @(negedge clk);
        abort = 1'b0; fetch_ack = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, fnh_frm} !== 3'b000) begin
          n_err++; $display("FAIL %s abort_idle: busy/done/fnh got %b want 000", tag,
                            {busy, done, fnh_frm});
        end
        n_cmp++;
        if ({cnt_blk, cnt_frm, cnt_pat, cnt_lay} !== '0 || frt_row !== 1'b1) begin
          n_err++; $display("FAIL %s abort_clear: cnt got %h frt_row %b want 0/1", tag,
                            {cnt_blk, cnt_frm, cnt_pat, cnt_lay}, frt_row);
        end
        beats = k;
        $display("run %s: aborted after %0d beats", tag, k);
        return;
      end
      q = k;
      a = q % (lr + 1); q = q / (lr + 1);
      r = q % (nr + 1); q = q / (nr + 1);
      b = q % (nb + 1); q = q / (nb + 1);
      f = q % (nf + 1); q = q / (nf + 1);
      p = q % (np + 1); q = q / (np + 1);
      l = q;
      exp_f[7] = (a == 0);
      exp_f[6] = (a == lr);
      exp_f[5] = (b == 0);
      exp_f[4] = exp_f[6] && (r == nr);
      exp_f[3] = exp_f[4] && (b == nb);
      exp_f[2] = exp_f[3] && (f == nf);
      exp_f[1] = exp_f[2] && (p == np) && (l == nl);
      exp_f[0] = (r >= dr);
      got_f = {frt_row, lst_row, frt_blk, lst_blk, lst_frm, lst_pat, lst_lay, val_psum};
      exp_c = {BLK_W'(b), FRM_W'(f), PAT_W'(p), LAY_W'(l)};
      got_c = {cnt_blk, cnt_frm, cnt_pat, cnt_lay};
      n_cmp++;
      if (fetch_req !== 1'b1 || busy !== 1'b1) begin
        n_err++; $display("FAIL %s req_busy beat %0d: got %b%b want 11", tag, k, fetch_req, busy);
      end
      n_cmp++;
      if (got_f !== exp_f) begin
        n_err++; $display("FAIL %s flags beat %0d: got %b want %b", tag, k, got_f, exp_f);
      end
      n_cmp++;
      if (got_c !== exp_c) begin
        n_err++; $display("FAIL %s counters beat %0d: got %h want %h", tag, k, got_c, exp_c);
      end
      n_cmp++;
      if (fnh_frm !== exp_fnh || done !== 1'b0) begin
        n_err++; $display("FAIL %s fnh_done beat %0d: got %b%b want %b0", tag, k,
                          fnh_frm, done, exp_fnh);
      end
      fnh_next = fetch_ack && exp_f[3];
      if (fetch_ack) k++;
      exp_fnh = fnh_next;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; fetch_ack = 1'b0;
    beats = k;
    if (k < total) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, k, total);
      return;
    end
    #1;
    n_cmp++;
    if ({done, fnh_frm, fetch_req, busy} !== {1'b1, exp_fnh, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL %s fin: done/fnh/req/busy got %b want %b", tag,
                        {done, fnh_frm, fetch_req, busy}, {1'b1, exp_fnh, 1'b0, 1'b1});
    end
    n_cmp++;
    if ({cnt_blk, cnt_frm, cnt_pat, cnt_lay} !== '0) begin
      n_err++; $display("FAIL %s fin_clear: got %h want 0", tag, {cnt_blk, cnt_frm, cnt_pat, cnt_lay});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, fnh_frm, fetch_req} !== 4'b0000) begin
      n_err++; $display("FAIL %s idle_after: busy/done/fnh/req got %b want 0000", tag,
                        {busy, done, fnh_frm, fetch_req});
    end
    $display("run %s: %0d beats in %0d cycles", tag, k, cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, fetch_req, done, fnh_frm} !== 4'b0000 || {frt_row, frt_blk} !== 2'b11) begin
      n_err++; $display("FAIL reset_outputs: got %b %b want 0000 11",
                        {busy, fetch_req, done, fnh_frm}, {frt_row, frt_blk});
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (fetch_req !== 1'b0 || {cnt_blk, cnt_frm, cnt_pat, cnt_lay} !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_ack_ignored: req %b busy %b cnt %h want 0 0 0",
                        fetch_req, busy, {cnt_blk, cnt_frm, cnt_pat, cnt_lay});
    end
    fetch_ack = 1'b0;
    $display("reset and idle ack checked");
  endtask

  task automatic test_all_zero();
    int beats;
    run_and_check("all_zero", 0, 0, 0, 0, 0, 0, 0, 100, -1, 1'b0, beats);
    n_cmp++;
    if (beats !== 1) begin
      n_err++; $display("FAIL all_zero_beats: got %0d want 1", beats);
    end
  endtask

  task automatic test_basic();
    int beats;
    run_and_check("basic64", 3, 3, 0, 1, 1, 0, 0, 100, -1, 1'b0, beats);
    n_cmp++;
    if (beats !== 64) begin
      n_err++; $display("FAIL basic64_beats: got %0d want 64", beats);
    end
  endtask

  task automatic test_random_ack();
    int beats;
    run_and_check("rand_ack", 3, 3, 0, 1, 1, 0, 0, 40, -1, 1'b0, beats);
    n_cmp++;
    if (beats !== 64) begin
      n_err++; $display("FAIL rand_ack_beats: got %0d want 64", beats);
    end
  endtask

  task automatic test_drop_rows();
    int beats;
    run_and_check("drop2", 3, 3, 2, 1, 1, 0, 0, 70, -1, 1'b0, beats);
    run_and_check("drop5", 3, 3, 5, 1, 0, 0, 0, 100, -1, 1'b0, beats);
    n_cmp++;
    if (beats !== 32) begin
      n_err++; $display("FAIL drop5_beats: got %0d want 32", beats);
    end
  endtask

  task automatic test_abort();
    int beats;
    run_and_check("abort20", 3, 3, 0, 1, 1, 0, 0, 100, 20, 1'b0, beats);
    n_cmp++;
    if (beats !== 20) begin
      n_err++; $display("FAIL abort20_beats: got %0d want 20", beats);
    end
    run_and_check("after_abort", 3, 3, 0, 1, 1, 0, 0, 100, -1, 1'b0, beats);
    n_cmp++;
    if (beats !== 64) begin
      n_err++; $display("FAIL after_abort_beats: got %0d want 64", beats);
    end
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    n_cmp++;
    if ({busy, fetch_req} !== 2'b00) begin
      n_err++; $display("FAIL abort_beats_start: busy/req got %b want 00", {busy, fetch_req});
    end
    $display("abort+start coincidence checked");
  endtask

  task automatic test_mid_start_layers();
    int beats;
    run_and_check("layers2", 3, 3, 0, 1, 1, 0, 1, 100, -1, 1'b1, beats);
    n_cmp++;
    if (beats !== 128) begin
      n_err++; $display("FAIL layers2_beats: got %0d want 128", beats);
    end
    run_and_check("layers2_rand", 3, 3, 1, 1, 1, 0, 1, 60, -1, 1'b1, beats);
    n_cmp++;
    if (beats !== 128) begin
      n_err++; $display("FAIL layers2_rand_beats: got %0d want 128", beats);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_basic();
    test_random_ack();
    test_drop_rows();
    test_abort();
    test_abort_start_idle();
    test_mid_start_layers();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
